// File: rtl/br_pkg.sv
// br_pkg: opcodes, function codes and 2-bit saturating counter helpers for branch resolution
package br_pkg;

    localparam logic [4:0] OPC_JUMP   = 5'b00011;
    localparam logic [4:0] OPC_BRANCH = 5'b00100;

    localparam logic [3:0] FUNC_JMP  = 4'b0000;
    localparam logic [3:0] FUNC_CALL = 4'b0001;
    localparam logic [3:0] FUNC_BZ   = 4'b0000;
    localparam logic [3:0] FUNC_BLTZ = 4'b0001;
    localparam logic [3:0] FUNC_BGTZ = 4'b0010;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_WNT = 2'b01;

    function automatic ctr_t ctrInc(input ctr_t c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic ctr_t ctrDec(input ctr_t c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/br_pred_table.sv
// br_pred_table: table of 2-bit saturating direction counters, async read, sync train, async reset
module br_pred_table
    import br_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rdIdx,
    output ctr_t             rdCtr,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic             wrTaken
);

    ctr_t table_q [DEPTH];

    // read returns the stored value, so a same-cycle update is seen only next cycle
    assign rdCtr = table_q[rdIdx];

    // every counter starts weakly not-taken; training nudges one counter toward the outcome
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= CTR_WNT;
        end else if (wrEn) begin
            table_q[wrIdx] <= wrTaken ? ctrInc(table_q[wrIdx]) : ctrDec(table_q[wrIdx]);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: one-stage registered jump/call/branch resolver with predictor table
// Optional BRU_STATS_EN adds saturating branch and mispredict counters with sync clear.
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 32,
    parameter int PRED_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [3:0]        in_func,
    input  logic [DATA_W-1:0] in_reg1,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_pred_taken,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_taken,
    output logic              out_link,
    output logic              out_mispredict,
    output logic              out_illegal,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_taken
`ifdef BRU_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(PRED_DEPTH);

    logic accept, jmpOk, brOk, legal, regZero, regNeg, brTaken, taken, link, mispredict;
    ctr_t predCtr;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign jmpOk      = in_opcode == OPC_JUMP && (in_func == FUNC_JMP || in_func == FUNC_CALL);
    assign brOk       = in_opcode == OPC_BRANCH &&
                        (in_func == FUNC_BZ || in_func == FUNC_BLTZ || in_func == FUNC_BGTZ);
    assign legal      = jmpOk || brOk;
    assign regZero    = in_reg1 == '0;
    assign regNeg     = in_reg1[DATA_W-1];
    assign brTaken    = (in_func == FUNC_BZ)   ? regZero :
                        (in_func == FUNC_BLTZ) ? regNeg  : !regNeg && !regZero;
    assign taken      = jmpOk || (brOk && brTaken);
    assign link       = jmpOk && in_func == FUNC_CALL;
    assign mispredict = legal && (taken != in_pred_taken);
    assign pred_taken = predCtr[1];

    br_pred_table #(.DEPTH(PRED_DEPTH), .IDX_W(IDX_W)) uTable (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdIdx   (pred_pc[IDX_W+1:2]),
        .rdCtr   (predCtr),
        .wrEn    (accept && brOk),
        .wrIdx   (in_pc[IDX_W+1:2]),
        .wrTaken (taken)
    );

    // result registers load on accept; valid drops only when drained with nothing new arriving
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_link       <= 1'b0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_taken      <= taken;
            out_link       <= link;
            out_mispredict <= mispredict;
            out_illegal    <= !legal;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end
    end

`ifdef BRU_STATS_EN
    // saturating event counters; clear takes priority over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (stat_clr) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (accept && legal && !(&stat_branches)) stat_branches <= stat_branches + 32'd1;
            if (accept && mispredict && !(&stat_mispredicts)) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_opcode;
    logic [3:0]  in_func;
    logic [31:0] in_reg1, in_pc, pred_pc;
    logic        in_pred_taken;
    logic        out_valid, out_ready, out_taken, out_link, out_mispredict, out_illegal;
    logic        pred_taken;
`ifdef BRU_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_func        (in_func),
        .in_reg1        (in_reg1),
        .in_pc          (in_pc),
        .in_pred_taken  (in_pred_taken),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_link       (out_link),
        .out_mispredict (out_mispredict),
        .out_illegal    (out_illegal),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken)
`ifdef BRU_STATS_EN
        ,
        .stat_clr        (stat_clr),
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // present one instruction for a single cycle; outputs are sampled 1ns after the edge
    task automatic issue(input logic [4:0] op, input logic [3:0] fn, input logic [31:0] r,
                         input logic [31:0] pc, input logic pr);
        in_opcode = op; in_func = fn; in_reg1 = r; in_pc = pc; in_pred_taken = pr;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic checkOut(input string tag, input logic v, input logic t, input logic l,
                            input logic m, input logic il);
        checkVal({tag, ".valid"}, 32'(out_valid), 32'(v));
        checkVal({tag, ".taken"}, 32'(out_taken), 32'(t));
        checkVal({tag, ".link"}, 32'(out_link), 32'(l));
        checkVal({tag, ".mispred"}, 32'(out_mispredict), 32'(m));
        checkVal({tag, ".illegal"}, 32'(out_illegal), 32'(il));
    endtask

    task automatic checkPred(input string tag, input logic [31:0] pc, input logic exp);
        pred_pc = pc;
        #1;
        checkVal(tag, 32'(pred_taken), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_func = '0; in_reg1 = '0; in_pc = '0; in_pred_taken = 1'b0; pred_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOut("reset", 0, 0, 0, 0, 0);
        checkVal("reset.in_ready", 32'(in_ready), 32'd1);
        checkPred("reset.pred", 32'h10, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: BZ taken on fresh counter, predicted not-taken
        issue(5'b00100, 4'b0000, 32'h0, 32'h10, 1'b0);
        checkOut("bz", 1, 1, 0, 1, 0);
        checkPred("bz.pred", 32'h10, 1'b1);
        checkPred("bz.other", 32'h14, 1'b0);

        // 2: signed compares
        issue(5'b00100, 4'b0001, 32'h8000_0000, 32'h20, 1'b0);
        checkOut("bltz.neg", 1, 1, 0, 1, 0);
        issue(5'b00100, 4'b0010, 32'h8000_0000, 32'h24, 1'b1);
        checkOut("bgtz.neg", 1, 0, 0, 1, 0);
        issue(5'b00100, 4'b0010, 32'h1, 32'h28, 1'b1);
        checkOut("bgtz.one", 1, 1, 0, 0, 0);
        issue(5'b00100, 4'b0000, 32'h5, 32'h2c, 1'b0);
        checkOut("bz.nz", 1, 0, 0, 0, 0);
        issue(5'b00100, 4'b0001, 32'h7fff_ffff, 32'h2c, 1'b1);
        checkOut("bltz.pos", 1, 0, 0, 1, 0);

        // 3: call and plain jump never train
        issue(5'b00011, 4'b0001, 32'h0, 32'h30, 1'b1);
        checkOut("call", 1, 1, 1, 0, 0);
        checkPred("call.pred", 32'h30, 1'b0);
        issue(5'b00011, 4'b0000, 32'h0, 32'h34, 1'b0);
        checkOut("jmp", 1, 1, 0, 1, 0);
        @(posedge clk); #1;
        checkVal("drain.valid", 32'(out_valid), 32'd0);

        // 4: backpressure holds the result and blocks the next instruction
        out_ready = 1'b0;
        issue(5'b00100, 4'b0000, 32'h0, 32'h40, 1'b1);
        checkOut("bp.first", 1, 1, 0, 0, 0);
        in_opcode = 5'b00100; in_func = 4'b0001; in_reg1 = 32'h1; in_pc = 32'h44; in_pred_taken = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkVal("bp.in_ready", 32'(in_ready), 32'd0);
            checkOut("bp.hold", 1, 1, 0, 0, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checkVal("bp.release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOut("bp.second", 1, 0, 0, 1, 0);
        checkPred("bp.pred", 32'h40, 1'b1);
        @(posedge clk); #1;

        // 5: illegal combinations leave the table alone (0x50 aliases 0x10)
        issue(5'b00111, 4'b0000, 32'h0, 32'h50, 1'b1);
        checkOut("illegal.opc", 1, 0, 0, 0, 1);
        issue(5'b00100, 4'b0011, 32'h0, 32'h50, 1'b1);
        checkOut("illegal.func", 1, 0, 0, 0, 1);
        issue(5'b00011, 4'b0010, 32'h0, 32'h50, 1'b0);
        checkOut("illegal.jfunc", 1, 0, 0, 0, 1);
        checkPred("illegal.pred", 32'h10, 1'b1);

        // saturation: four taken then two not-taken lands at 01 only if capped at 11
        for (int i = 0; i < 4; i++) issue(5'b00100, 4'b0000, 32'h0, 32'h1c, 1'b1);
        checkPred("sat.top", 32'h1c, 1'b1);
        issue(5'b00100, 4'b0000, 32'h9, 32'h1c, 1'b1);
        checkPred("sat.dec1", 32'h1c, 1'b1);
        in_opcode = 5'b00100; in_func = 4'b0000; in_reg1 = 32'h9; in_pc = 32'h1c; in_pred_taken = 1'b1;
        in_valid = 1'b1;
        #1;
        checkVal("rbw.old", 32'(pred_taken), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkVal("rbw.new", 32'(pred_taken), 32'd0);

        // 6: async reset drops a held result and restores counters
        out_ready = 1'b0;
        issue(5'b00011, 4'b0001, 32'h0, 32'h60, 1'b0);
        checkVal("rst.held", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOut("rst.mid", 0, 0, 0, 0, 0);
        checkPred("rst.pred", 32'h10, 1'b0);
        checkPred("rst.pred2", 32'h20, 1'b0);
`ifdef BRU_STATS_EN
        checkVal("rst.stat_br", stat_branches, 32'd0);
        checkVal("rst.stat_mp", stat_mispredicts, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
